fir_peak_meter: RTL and testbench

- Sample-stream receiver placed on the output of fir_core (or any signed audio stream).
- Measures peak absolute amplitude over fixed windows of WIN_LEN accepted samples. Also records the in-window index of the peak.
- Each window result is presented through a valid/ready result port.
- Gives an in-circuit replacement for the HPF/LPF amplitude-discrimination checks, so a bench or CPU can read per-window peaks.

---
 rtl/fir_meter_pkg.sv | 17 +
 rtl/fir_peak_acc.sv | 29 ++
 rtl/fir_peak_meter.sv | 141 ++++++++++++++
 tb/tb_fir_peak_meter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_meter_pkg.sv
// Shared types and helpers for the FIR output peak meter.
package fir_meter_pkg;

  typedef enum logic {IDLE, ACC} meter_state_t;

  localparam int unsigned WIN_LEN_DEFAULT = 4800;

  // Widest sample abs_u accepts; callers cast to and from their own width.
  localparam int unsigned ABS_MAXW = 64;

  // Two's-complement magnitude without saturation: the most negative value
  // maps to 2^(W-1) once the caller truncates back to W bits.
  function automatic logic [ABS_MAXW-1:0] abs_u(input logic signed [ABS_MAXW-1:0] x);
    return x[ABS_MAXW-1] ? ABS_MAXW'(-x) : ABS_MAXW'(x);
  endfunction

endpackage

// File: rtl/fir_peak_acc.sv
// Combinational running-extremum update: strict compare, ties keep the earlier index.
module fir_peak_acc #(
  parameter int unsigned DATAW  = 16,
  parameter int unsigned CNTW   = 13,
  parameter bit          IS_SIGNED = 1'b0,
  parameter bit          IS_MIN    = 1'b0
) (
  input  logic [DATAW-1:0] acc_val,
  input  logic [CNTW-1:0]  acc_idx,
  input  logic [DATAW-1:0] val,
  input  logic [CNTW-1:0]  cnt,
  output logic [DATAW-1:0] nxt_val_c,
  output logic [CNTW-1:0]  nxt_idx_c
);

  logic upd_c;

  always_comb begin
    upd_c = 1'b0;
    if (IS_SIGNED) begin
      upd_c = IS_MIN ? ($signed(val) < $signed(acc_val)) : ($signed(val) > $signed(acc_val));
    end else begin
      upd_c = IS_MIN ? (val < acc_val) : (val > acc_val);
    end
    nxt_val_c = upd_c ? val : acc_val;
    nxt_idx_c = upd_c ? cnt : acc_idx;
  end

endmodule

// File: rtl/fir_peak_meter.sv
// Per-window peak |din| meter with valid/ready result port and sticky overrun.
// Define FIR_PEAK_MINMAX_EN to add signed max_out/min_out per window.
module fir_peak_meter
  import fir_meter_pkg::*;
#(
  parameter int unsigned  DATAW   = 16,
  parameter int unsigned  WIN_LEN = WIN_LEN_DEFAULT,
  localparam int unsigned CNTW    = $clog2(WIN_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    clear_state,
  input  logic signed [DATAW-1:0] din,
  output logic [DATAW-1:0]        peak_out,
  output logic [CNTW-1:0]         peak_idx,
  output logic                    peak_valid,
  input  logic                    peak_ready,
  output logic                    overrun
`ifdef FIR_PEAK_MINMAX_EN
  ,
  output logic signed [DATAW-1:0] max_out,
  output logic signed [DATAW-1:0] min_out
`endif
);

  localparam logic [CNTW-1:0] LAST_IDX = CNTW'(WIN_LEN - 1);

  meter_state_t     state;
  logic [CNTW-1:0]  cnt, acc_idx;
  logic [DATAW-1:0] acc_peak;

  logic [CNTW-1:0]  cnt_in_c, acc_idx_in_c, nxt_idx_c;
  logic [DATAW-1:0] acc_peak_in_c, a_c, nxt_peak_c;
  logic             idle_c, last_c, xfer_c;

  // IDLE presents a fresh window to the compare regardless of held registers.
  assign idle_c        = (state == IDLE);
  assign cnt_in_c      = idle_c ? '0 : cnt;
  assign acc_peak_in_c = idle_c ? '0 : acc_peak;
  assign acc_idx_in_c  = idle_c ? '0 : acc_idx;
  assign a_c           = DATAW'(abs_u(ABS_MAXW'(din)));
  assign last_c        = (cnt_in_c == LAST_IDX);
  assign xfer_c        = peak_valid && peak_ready;

  fir_peak_acc #(.DATAW(DATAW), .CNTW(CNTW), .IS_SIGNED(1'b0), .IS_MIN(1'b0)) u_peak (
    .acc_val   (acc_peak_in_c),
    .acc_idx   (acc_idx_in_c),
    .val       (a_c),
    .cnt       (cnt_in_c),
    .nxt_val_c (nxt_peak_c),
    .nxt_idx_c (nxt_idx_c)
  );

`ifdef FIR_PEAK_MINMAX_EN
  localparam logic [DATAW-1:0] MAX_INIT = {1'b1, {(DATAW-1){1'b0}}};
  localparam logic [DATAW-1:0] MIN_INIT = {1'b0, {(DATAW-1){1'b1}}};

  logic [DATAW-1:0] acc_max, acc_min, acc_max_in_c, acc_min_in_c, nxt_max_c, nxt_min_c;
  logic [CNTW-1:0]  max_idx_unused, min_idx_unused;

  assign acc_max_in_c = idle_c ? MAX_INIT : acc_max;
  assign acc_min_in_c = idle_c ? MIN_INIT : acc_min;

  fir_peak_acc #(.DATAW(DATAW), .CNTW(CNTW), .IS_SIGNED(1'b1), .IS_MIN(1'b0)) u_max (
    .acc_val   (acc_max_in_c),
    .acc_idx   (acc_idx_in_c),
    .val       (din),
    .cnt       (cnt_in_c),
    .nxt_val_c (nxt_max_c),
    .nxt_idx_c (max_idx_unused)
  );

  fir_peak_acc #(.DATAW(DATAW), .CNTW(CNTW), .IS_SIGNED(1'b1), .IS_MIN(1'b1)) u_min (
    .acc_val   (acc_min_in_c),
    .acc_idx   (acc_idx_in_c),
    .val       (din),
    .cnt       (cnt_in_c),
    .nxt_val_c (nxt_min_c),
    .nxt_idx_c (min_idx_unused)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      acc_peak   <= '0;
      acc_idx    <= '0;
      peak_out   <= '0;
      peak_idx   <= '0;
      peak_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef FIR_PEAK_MINMAX_EN
      acc_max    <= MAX_INIT;
      acc_min    <= MIN_INIT;
      max_out    <= '0;
      min_out    <= '0;
`endif
    end else begin
      if (xfer_c) peak_valid <= 1'b0;
      // clear_state drops any coincident sample but leaves the result port alone.
      if (clear_state) begin
        state    <= IDLE;
        cnt      <= '0;
        acc_peak <= '0;
        acc_idx  <= '0;
`ifdef FIR_PEAK_MINMAX_EN
        acc_max  <= MAX_INIT;
        acc_min  <= MIN_INIT;
`endif
      end else if (en) begin
        state <= ACC;
        if (last_c) begin
          peak_out   <= nxt_peak_c;
          peak_idx   <= nxt_idx_c;
          peak_valid <= 1'b1;
          if (peak_valid && !peak_ready) overrun <= 1'b1;
          cnt        <= '0;
          acc_peak   <= '0;
          acc_idx    <= '0;
`ifdef FIR_PEAK_MINMAX_EN
          max_out    <= nxt_max_c;
          min_out    <= nxt_min_c;
          acc_max    <= MAX_INIT;
          acc_min    <= MIN_INIT;
`endif
        end else begin
          cnt      <= cnt_in_c + CNTW'(1);
          acc_peak <= nxt_peak_c;
          acc_idx  <= nxt_idx_c;
`ifdef FIR_PEAK_MINMAX_EN
          acc_max  <= nxt_max_c;
          acc_min  <= nxt_min_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_peak_meter.sv
// Directed bench for fir_peak_meter with WIN_LEN=8, DATAW=16.
module tb_fir_peak_meter;

  localparam int unsigned DATAW   = 16;
  localparam int unsigned WIN_LEN = 8;
  localparam int unsigned CNTW    = $clog2(WIN_LEN);

  logic                    clk;
  logic                    rst;
  logic                    en;
  logic                    clear_state;
  logic signed [DATAW-1:0] din;
  logic [DATAW-1:0]        peak_out;
  logic [CNTW-1:0]         peak_idx;
  logic                    peak_valid;
  logic                    peak_ready;
  logic                    overrun;
`ifdef FIR_PEAK_MINMAX_EN
  logic signed [DATAW-1:0] max_out;
  logic signed [DATAW-1:0] min_out;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  fir_peak_meter #(.DATAW(DATAW), .WIN_LEN(WIN_LEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .clear_state (clear_state),
    .din         (din),
    .peak_out    (peak_out),
    .peak_idx    (peak_idx),
    .peak_valid  (peak_valid),
    .peak_ready  (peak_ready),
    .overrun     (overrun)
`ifdef FIR_PEAK_MINMAX_EN
    ,
    .max_out     (max_out),
    .min_out     (min_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: inputs applied before the edge, outputs sampled 1 ns after it.
  task automatic step(input logic e, input logic signed [DATAW-1:0] d);
    en  = e;
    din = d;
    @(posedge clk);
    #1;
    en  = 1'b0;
    din = '0;
  endtask

  task automatic send_win(input logic signed [DATAW-1:0] s [8], input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, s[i]);
      if (i != 7) repeat (gap) step(1'b0, '0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, '0);
    step(1'b0, '0);
    rst = 1'b0;
  endtask

  logic signed [DATAW-1:0] w [8];

  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    clear_state = 1'b0;
    din         = '0;
    peak_ready  = 1'b0;
    do_reset();
    check("rst_peak_out",   32'(peak_out),   0);
    check("rst_peak_idx",   32'(peak_idx),   0);
    check("rst_peak_valid", 32'(peak_valid), 0);
    check("rst_overrun",    32'(overrun),    0);

    // Basic window, tie at 300 keeps index 2
    peak_ready = 1'b1;
    w = '{16'sd0, 16'sd100, -16'sd300, 16'sd200, -16'sd300, 16'sd50, 16'sd0, 16'sd10};
    send_win(w, 0);
    check("basic_valid", 32'(peak_valid), 1);
    check("basic_peak",  32'(peak_out),   300);
    check("basic_idx",   32'(peak_idx),   2);
`ifdef FIR_PEAK_MINMAX_EN
    check("basic_max", 32'(max_out), 200);
    check("basic_min", 32'(min_out), -300);
`endif
    step(1'b0, '0);
    check("basic_valid_drop", 32'(peak_valid), 0);

    // Most negative sample maps to 32768
    w = '{16'sd0, 16'sd0, 16'sd0, -16'sd32768, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_win(w, 0);
    check("extreme_peak", 32'(peak_out), 32768);
    check("extreme_idx",  32'(peak_idx), 3);
    step(1'b0, '0);
    check("extreme_valid_drop", 32'(peak_valid), 0);

    // Overrun: two windows without acceptance
    peak_ready = 1'b0;
    w = '{16'sd0, 16'sd500, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_win(w, 0);
    check("ovr_first_peak", 32'(peak_out), 500);
    check("ovr_first_ovr",  32'(overrun),  0);
    w = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd70, 16'sd0, 16'sd0};
    send_win(w, 0);
    check("ovr_peak",  32'(peak_out),   70);
    check("ovr_idx",   32'(peak_idx),   5);
    check("ovr_valid", 32'(peak_valid), 1);
    check("ovr_flag",  32'(overrun),    1);
    peak_ready = 1'b1;
    step(1'b0, '0);
    peak_ready = 1'b0;
    check("ovr_valid_drop", 32'(peak_valid), 0);
    check("ovr_sticky",     32'(overrun),    1);

    // Transfer and completion on the same edge
    do_reset();
    check("rst2_overrun", 32'(overrun), 0);
    w = '{16'sd11, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    send_win(w, 0);
    check("sim_first_peak", 32'(peak_out), 11);
    w = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd22, 16'sd0};
    for (int i = 0; i < 7; i++) step(1'b1, w[i]);
    peak_ready = 1'b1;
    step(1'b1, w[7]);
    check("sim_peak",  32'(peak_out),   22);
    check("sim_idx",   32'(peak_idx),   6);
    check("sim_valid", 32'(peak_valid), 1);
    check("sim_ovr",   32'(overrun),    0);
    step(1'b0, '0);
    check("sim_valid_drop", 32'(peak_valid), 0);

    // clear_state mid-window drops the coincident sample
    peak_ready = 1'b0;
    w = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd123, 16'sd0, 16'sd0, 16'sd0};
    send_win(w, 0);
    for (int i = 1; i <= 5; i++) step(1'b1, 16'(i));
    clear_state = 1'b1;
    step(1'b1, 16'sd9000);
    clear_state = 1'b0;
    check("clr_pending_peak",  32'(peak_out),   123);
    check("clr_pending_idx",   32'(peak_idx),   4);
    check("clr_pending_valid", 32'(peak_valid), 1);
    check("clr_ovr",           32'(overrun),    0);
    peak_ready = 1'b1;
    step(1'b0, '0);
    check("clr_xfer", 32'(peak_valid), 0);
    w = '{16'sd0, -16'sd40, 16'sd40, 16'sd5, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
    for (int i = 0; i < 7; i++) step(1'b1, w[i]);
    check("clr_no_early", 32'(peak_valid), 0);
    step(1'b1, w[7]);
    check("clr_peak",  32'(peak_out),   40);
    check("clr_idx",   32'(peak_idx),   1);
    check("clr_valid", 32'(peak_valid), 1);
    step(1'b0, '0);
    check("clr_valid_drop", 32'(peak_valid), 0);

    // Gapped strobes: en every third cycle
    peak_ready = 1'b0;
    w = '{16'sd0, 16'sd100, -16'sd300, 16'sd200, -16'sd300, 16'sd50, 16'sd0, 16'sd10};
    send_win(w, 2);
    check("gap_valid", 32'(peak_valid), 1);
    check("gap_peak",  32'(peak_out),   300);
    check("gap_idx",   32'(peak_idx),   2);
    check("gap_ovr",   32'(overrun),    0);

    // Reset mid-window discards partial window and pending result
    step(1'b1, 16'sd500);
    step(1'b0, '0);
    step(1'b1, 16'sd7);
    rst = 1'b1;
    step(1'b1, 16'sd1);
    rst = 1'b0;
    check("midrst_peak",  32'(peak_out),   0);
    check("midrst_idx",   32'(peak_idx),   0);
    check("midrst_valid", 32'(peak_valid), 0);
    check("midrst_ovr",   32'(overrun),    0);

    // Fresh window after reset: peak on the last index
    peak_ready = 1'b1;
    w = '{16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, -16'sd7};
    send_win(w, 0);
    check("post_peak",  32'(peak_out),   7);
    check("post_idx",   32'(peak_idx),   7);
    check("post_valid", 32'(peak_valid), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
